// File: rtl/banked_mem_responder_pkg.sv
// Shared constants and types for the banked main-memory responder.
package banked_mem_responder_pkg;

    localparam int unsigned ADDR_W       = 16;
    localparam int unsigned DATA_W       = 16;
    localparam int unsigned NUM_BANKS    = 4;
    localparam int unsigned BANK_SEL_LSB = 1;
    localparam int unsigned BANK_SEL_MSB = 2;
    localparam int unsigned BANK_SEL_W   = BANK_SEL_MSB - BANK_SEL_LSB + 1;
    localparam int unsigned BANK_WORDS   = 2048;
    localparam int unsigned IDX_LSB      = 3;
    localparam int unsigned IDX_W        = $clog2(BANK_WORDS);
    localparam int unsigned BANK_CYCLES  = 4;
    localparam int unsigned CNT_W        = $clog2(BANK_CYCLES + 1);
    localparam int unsigned RD_LAT       = 2;

    typedef logic [BANK_SEL_W-1:0] bank_sel_t;
    typedef logic [IDX_W-1:0]      bank_idx_t;

    // One stage of the read-return pipe; data is zero whenever valid is low.
    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] data;
    } rd_ret_t;

endpackage

// File: rtl/banked_mem_responder_if.sv
// Request/response bus between the L1 cache controller and the memory responder.
interface banked_mem_responder_if;
    import banked_mem_responder_pkg::*;

    logic [ADDR_W-1:0]    addr;
    logic [DATA_W-1:0]    data_in;
    logic                 wr;
    logic                 rd;
    logic [DATA_W-1:0]    data_out;
    logic                 rd_valid;
    logic [NUM_BANKS-1:0] busy;
    logic                 stall;
    logic                 err;

    modport master (
        output addr, data_in, wr, rd,
        input  data_out, rd_valid, busy, stall, err
    );

    modport slave (
        input  addr, data_in, wr, rd,
        output data_out, rd_valid, busy, stall, err
    );

endinterface

// File: rtl/banked_mem_responder_mem_bank.sv
// One memory bank: word array, write port and occupancy down-counter.
module banked_mem_responder_mem_bank
    import banked_mem_responder_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              sel,
    input  logic              we,
    input  logic              re,
    input  bank_idx_t         idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              busy
);

    logic [DATA_W-1:0] mem [BANK_WORDS];
    logic [CNT_W-1:0]  cnt_q;

    // Occupancy counter: load on accept, count down to zero and hold.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (sel) begin
            cnt_q <= CNT_W'(BANK_CYCLES);
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // Write port; array contents survive reset.
    always_ff @(posedge clk) begin
        if (sel && we) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata = re ? mem[idx] : '0;
    assign busy  = (cnt_q != '0);

endmodule

// File: rtl/banked_mem_responder.sv
// Four-bank word-interleaved memory responder with fixed-latency read return.
module banked_mem_responder
    import banked_mem_responder_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    banked_mem_responder_if.slave bus
);

    logic                 req;
    logic                 illegal;
    logic                 accept;
    logic                 accept_rd;
    bank_sel_t            bank;
    bank_idx_t            idx;
    logic [NUM_BANKS-1:0] busy_w;
    logic [DATA_W-1:0]    rdata_w [NUM_BANKS];
    rd_ret_t              pipe_q  [RD_LAT];
    logic                 err_q;
    logic [ADDR_W-IDX_LSB-IDX_W-1:0] unused_addr_hi;

    // Address decode; bits above the bank index range are ignored.
    assign bank           = bus.addr[BANK_SEL_MSB:BANK_SEL_LSB];
    assign idx            = bus.addr[IDX_LSB +: IDX_W];
    assign unused_addr_hi = bus.addr[ADDR_W-1:IDX_LSB+IDX_W];

    // Request classification: illegal wins over stall, stall blocks acceptance.
    assign req       = bus.rd | bus.wr;
    assign illegal   = (bus.rd & bus.wr) | (req & bus.addr[0]);
    assign bus.stall = req & ~illegal & busy_w[bank];
    assign accept    = rst & req & ~illegal & ~busy_w[bank];
    assign accept_rd = accept & bus.rd;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        banked_mem_responder_mem_bank u_bank (
            .clk   (clk),
            .rst   (rst),
            .sel   (accept && (bank == BANK_SEL_W'(b))),
            .we    (bus.wr),
            .re    (bus.rd),
            .idx   (idx),
            .wdata (bus.data_in),
            .rdata (rdata_w[b]),
            .busy  (busy_w[b])
        );
    end

    // Read-return pipe: word captured at accept, emerges RD_LAT cycles later.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0].valid <= accept_rd;
            pipe_q[0].data  <= accept_rd ? rdata_w[bank] : '0;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    // One-cycle error pulse for a malformed request.
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= illegal;
        end
    end

    assign bus.rd_valid = pipe_q[RD_LAT-1].valid;
    assign bus.data_out = pipe_q[RD_LAT-1].data;
    assign bus.busy     = busy_w;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_banked_mem_responder.sv
// Scoreboard bench for banked_mem_responder.
module tb_banked_mem_responder;
    import banked_mem_responder_pkg::*;

    typedef struct {
        logic [DATA_W-1:0] data;
        int                due;
    } exp_t;

    logic              clk;
    logic              rst;
    int                cyc;
    int                n_cmp;
    int                n_err;
    bit                mon_en;
    exp_t              exp_q[$];
    exp_t              mon_e;
    logic [DATA_W-1:0] model [int];

    banked_mem_responder_if bus ();

    banked_mem_responder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Single comparison point: count and report.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one request for one cycle; record expected side effects if it should be taken.
    task automatic req(input logic r, input logic w, input logic [15:0] a,
                       input logic [15:0] d, input logic exp_stall, input string tag);
        logic legal;
        int   key;
        bus.rd      = r;
        bus.wr      = w;
        bus.addr    = a;
        bus.data_in = d;
        legal = (r ^ w) && !a[0];
        key   = int'(a[13:1]);
        @(negedge clk);
        check({tag, "_stall"}, 32'(bus.stall), 32'(exp_stall));
        if (legal && !exp_stall && rst) begin
            if (w) model[key] = d;
            else   exp_q.push_back('{model.exists(key) ? model[key] : 16'h0, cyc + int'(RD_LAT)});
        end
        @(posedge clk);
        #1;
        bus.rd = 1'b0;
        bus.wr = 1'b0;
    endtask

    // Return monitor: pop and compare every rd_valid; outside strobes data_out must be 0.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.rd_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("rd_valid_spurious", 32'(1), 32'(0));
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rd_data", 32'(bus.data_out), 32'(mon_e.data));
                    check("rd_latency", 32'(cyc), 32'(mon_e.due));
                end
            end else begin
                check("rd_valid_low", 32'(bus.rd_valid), 32'(0));
                check("data_out_idle", 32'(bus.data_out), 32'(0));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc         = 0;
        n_cmp       = 0;
        n_err       = 0;
        mon_en      = 1'b0;
        rst         = 1'b0;
        bus.rd      = 1'b1;
        bus.wr      = 1'b0;
        bus.addr    = 16'h0010;
        bus.data_in = 16'h0000;

        // Reset held two cycles with rd asserted.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'(0));
        check("rst_rd_valid", 32'(bus.rd_valid), 32'(0));
        check("rst_err", 32'(bus.err), 32'(0));
        check("rst_data_out", 32'(bus.data_out), 32'(0));
        @(posedge clk);
        #1;
        rst    = 1'b1;
        bus.rd = 1'b0;
        mon_en = 1'b1;

        // Write then read back after the bank frees.
        req(1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0, "wr_beef");
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("busy0_held", 32'(bus.busy[0]), 32'(1));
            @(posedge clk);
            #1;
        end
        req(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, "rd_beef");
        tick(4);

        // Same-bank back-to-back: second request stalls until busy[1] falls.
        req(1'b0, 1'b1, 16'h000A, 16'h5A5A, 1'b0, "wr_a");
        tick(5);
        req(1'b0, 1'b1, 16'h0002, 16'h1234, 1'b0, "wr_2");
        repeat (4) req(1'b1, 1'b0, 16'h000A, 16'h0000, 1'b1, "rd_a_blocked");
        req(1'b1, 1'b0, 16'h000A, 16'h0000, 1'b0, "rd_a_go");
        tick(5);
        req(1'b1, 1'b0, 16'h0002, 16'h0000, 1'b0, "rd_2");
        tick(5);

        // Four banks on consecutive cycles overlap without stalls.
        for (int i = 0; i < 4; i++) begin
            req(1'b0, 1'b1, 16'(2 * i), 16'(16'hA000 + i), 1'b0, "ovl_wr");
        end
        @(negedge clk);
        check("ovl_busy_all", 32'(bus.busy), 32'(4'b1111));
        tick(1);
        tick(4);
        for (int i = 0; i < 4; i++) begin
            req(1'b1, 1'b0, 16'(2 * i), 16'h0000, 1'b0, "ovl_rd");
        end
        tick(5);

        // Illegal rd&wr: err pulse, no bank occupied, no write performed.
        req(1'b0, 1'b1, 16'h0020, 16'h1111, 1'b0, "wr_20");
        tick(5);
        req(1'b1, 1'b1, 16'h0020, 16'h7777, 1'b0, "err_rdwr");
        @(negedge clk);
        check("err_rdwr_pulse", 32'(bus.err), 32'(1));
        check("err_rdwr_busy", 32'(bus.busy), 32'(0));
        tick(1);
        @(negedge clk);
        check("err_rdwr_clear", 32'(bus.err), 32'(0));
        tick(1);
        req(1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, "rd_20");
        tick(4);

        // Odd address read: err pulse, no return.
        req(1'b1, 1'b0, 16'h0003, 16'h0000, 1'b0, "err_odd");
        @(negedge clk);
        check("err_odd_pulse", 32'(bus.err), 32'(1));
        check("err_odd_busy", 32'(bus.busy), 32'(0));
        tick(1);
        @(negedge clk);
        check("err_odd_clear", 32'(bus.err), 32'(0));
        tick(4);

        // Reset right after a read is accepted drops the return.
        req(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, "rd_pre_rst");
        rst = 1'b0;
        exp_q.delete();
        tick(1);
        @(negedge clk);
        check("midrst_busy", 32'(bus.busy), 32'(0));
        check("midrst_rd_valid", 32'(bus.rd_valid), 32'(0));
        tick(1);
        rst = 1'b1;
        tick(6);

        check("queue_drained", 32'(exp_q.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
